// File: rtl/frontend_cmd_issuer.sv
// Frontend command issuer: buffers host requests, issues them in order to the backend
// controller, and uses read credits so every issued read has a guaranteed return slot.
module frontend_cmd_issuer #(
    parameter int ROW_W     = 16,
    parameter int COL_W     = 4,
    parameter int DATA_W    = 128,
    parameter int CMD_DEPTH = 8,
    parameter int RD_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   power_on_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_op,
    input  logic [ROW_W-1:0]       i_req_row,
    input  logic [COL_W-1:0]       i_req_col,
    input  logic [DATA_W-1:0]      i_req_wdata,
    output logic                   o_frontend_command_valid,
    input  logic                   i_backend_controller_ready,
    output logic [ROW_W+COL_W:0]   o_frontend_command,
    output logic [DATA_W-1:0]      o_frontend_write_data,
    input  logic                   i_backend_read_data_valid,
    input  logic [DATA_W-1:0]      i_backend_read_data,
    output logic                   o_backend_controller_ren,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [DATA_W-1:0]      o_rsp_data,
    output logic                   o_busy,
    output logic                   o_overflow_err
);

    localparam int CMD_W = 1 + ROW_W + COL_W;
    localparam int CA    = $clog2(CMD_DEPTH);
    localparam int RA    = $clog2(RD_DEPTH);
    localparam int OW    = RA + 1;
    localparam logic [OW:0] RD_LIMIT = (OW+1)'(RD_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [CMD_W-1:0]  cmdMem_q [CMD_DEPTH];
    logic [DATA_W-1:0] wdMem_q  [CMD_DEPTH];
    logic [CA:0]       cmdWr_q, cmdRd_q, cmdCount;
    logic              cmdEmpty, cmdFull, cmdPush, cmdPop;
    logic [CA-1:0]     headIdx, nextIdx, loadIdx;

    logic [DATA_W-1:0] rdMem_q [RD_DEPTH];
    logic [RA:0]       rdWr_q, rdRd_q, rdCount;
    logic              rdEmpty, rdFull, rdPush, rdPop;

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  cmdOut_q;
    logic [DATA_W-1:0] wdOut_q;
    logic              load;

    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic              overflow_q;
    logic [OW:0]       creditUsed, creditNext;
    logic              headOk, nextOk, curIsRead, issueRead, creditRet;

    assign cmdEmpty = (cmdWr_q == cmdRd_q);
    assign cmdFull  = (cmdWr_q[CA] != cmdRd_q[CA]) && (cmdWr_q[CA-1:0] == cmdRd_q[CA-1:0]);
    assign cmdCount = cmdWr_q - cmdRd_q;
    assign cmdPush  = i_req_valid && !cmdFull;
    assign cmdPop   = (state_q == ISSUE) && i_backend_controller_ready;
    assign headIdx  = cmdRd_q[CA-1:0];
    assign nextIdx  = headIdx + CA'(1);

    assign rdEmpty  = (rdWr_q == rdRd_q);
    assign rdFull   = (rdWr_q[RA] != rdRd_q[RA]) && (rdWr_q[RA-1:0] == rdRd_q[RA-1:0]);
    assign rdCount  = rdWr_q - rdRd_q;
    assign rdPush   = i_backend_read_data_valid && !rdFull;
    assign rdPop    = !rdEmpty && i_rsp_ready;

    // The read being accepted this cycle is counted so a back-to-back read never over-commits.
    assign curIsRead  = !cmdOut_q[CMD_W-1];
    assign issueRead  = cmdPop && curIsRead;
    assign creditRet  = i_backend_read_data_valid && (outstanding_q != '0);
    assign creditUsed = {1'b0, outstanding_q} + {1'b0, rdCount};
    assign creditNext = creditUsed + (OW+1)'(curIsRead);
    assign headOk     = cmdMem_q[headIdx][CMD_W-1] || (creditUsed < RD_LIMIT);
    assign nextOk     = cmdMem_q[nextIdx][CMD_W-1] || (creditNext < RD_LIMIT);

    always_ff @(posedge clk) begin
        if (cmdPush) begin
            cmdMem_q[cmdWr_q[CA-1:0]] <= {i_req_op, i_req_row, i_req_col};
            wdMem_q[cmdWr_q[CA-1:0]]  <= i_req_wdata;
        end
        if (rdPush) begin
            rdMem_q[rdWr_q[RA-1:0]] <= i_backend_read_data;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        loadIdx = headIdx;
        case (state_q)
            IDLE: begin
                if (!cmdEmpty && headOk) begin
                    state_d = ISSUE;
                    load    = 1'b1;
                end
            end
            ISSUE: begin
                if (i_backend_controller_ready) begin
                    if ((cmdCount > (CA+1)'(1)) && nextOk) begin
                        load    = 1'b1;
                        loadIdx = nextIdx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (issueRead && !creditRet) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!issueRead && creditRet) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            cmdWr_q       <= '0;
            cmdRd_q       <= '0;
            rdWr_q        <= '0;
            rdRd_q        <= '0;
            state_q       <= IDLE;
            cmdOut_q      <= '0;
            wdOut_q       <= '0;
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (cmdPush) cmdWr_q <= cmdWr_q + (CA+1)'(1);
            if (cmdPop)  cmdRd_q <= cmdRd_q + (CA+1)'(1);
            if (rdPush)  rdWr_q  <= rdWr_q + (RA+1)'(1);
            if (rdPop)   rdRd_q  <= rdRd_q + (RA+1)'(1);
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            if (load) begin
                cmdOut_q <= cmdMem_q[loadIdx];
                wdOut_q  <= wdMem_q[loadIdx];
            end
            if (i_backend_read_data_valid && rdFull) overflow_q <= 1'b1;
        end
    end

    assign o_req_ready              = !cmdFull;
    assign o_frontend_command_valid = (state_q == ISSUE);
    assign o_frontend_command       = cmdOut_q;
    assign o_frontend_write_data    = wdOut_q;
    assign o_backend_controller_ren = !rdFull;
    assign o_rsp_valid              = !rdEmpty;
    assign o_rsp_data               = rdMem_q[rdRd_q[RA-1:0]];
    assign o_busy                   = !cmdEmpty || (state_q != IDLE) || (outstanding_q != '0);
    assign o_overflow_err           = overflow_q;

endmodule

// File: tb/tb_frontend_cmd_issuer.sv
// Testbench for frontend_cmd_issuer: directed scenarios plus random traffic, scored against
// a transaction-level model built from queues of pending commands and buffered responses.
module tb_frontend_cmd_issuer;

    localparam int ROW_W     = 16;
    localparam int COL_W     = 4;
    localparam int DATA_W    = 128;
    localparam int CMD_DEPTH = 8;
    localparam int RD_DEPTH  = 4;
    localparam int CMD_W     = 1 + ROW_W + COL_W;

    logic              clk = 1'b0;
    logic              power_on_rst;
    logic              i_req_valid, i_req_op;
    logic [ROW_W-1:0]  i_req_row;
    logic [COL_W-1:0]  i_req_col;
    logic [DATA_W-1:0] i_req_wdata;
    logic              i_backend_controller_ready;
    logic              i_backend_read_data_valid;
    logic [DATA_W-1:0] i_backend_read_data;
    logic              i_rsp_ready;
    logic              o_req_ready, o_frontend_command_valid, o_backend_controller_ren;
    logic              o_rsp_valid, o_busy, o_overflow_err;
    logic [CMD_W-1:0]  o_frontend_command;
    logic [DATA_W-1:0] o_frontend_write_data, o_rsp_data;

    frontend_cmd_issuer #(
        .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
        .CMD_DEPTH(CMD_DEPTH), .RD_DEPTH(RD_DEPTH)
    ) dut (
        .clk(clk),
        .power_on_rst(power_on_rst),
        .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready),
        .i_req_op(i_req_op),
        .i_req_row(i_req_row),
        .i_req_col(i_req_col),
        .i_req_wdata(i_req_wdata),
        .o_frontend_command_valid(o_frontend_command_valid),
        .i_backend_controller_ready(i_backend_controller_ready),
        .o_frontend_command(o_frontend_command),
        .o_frontend_write_data(o_frontend_write_data),
        .i_backend_read_data_valid(i_backend_read_data_valid),
        .i_backend_read_data(i_backend_read_data),
        .o_backend_controller_ren(o_backend_controller_ren),
        .o_rsp_valid(o_rsp_valid),
        .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data),
        .o_busy(o_busy),
        .o_overflow_err(o_overflow_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [CMD_W-1:0]  cmdQ[$];
    logic [DATA_W-1:0] wdQ[$];
    logic [DATA_W-1:0] rspQ[$];
    int                outstanding;
    bit                ovfM;
    bit                pushed;
    int                acceptCount;
    int                stallCnt;
    int                validRun, maxRun;
    bit                stallPrev;
    logic [CMD_W-1:0]  prevCmd;
    logic [DATA_W-1:0] prevWd;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a falling edge: checks outputs against the model, then applies the effect of
    // the coming rising edge given the inputs currently driven.
    task automatic stepCycle();
        int outPre;
        bit reqOkPre, fullPre, popPre, issuable;
        outPre   = outstanding;
        reqOkPre = cmdQ.size() < CMD_DEPTH;
        fullPre  = rspQ.size() == RD_DEPTH;
        popPre   = (rspQ.size() != 0) && i_rsp_ready;

        checkOutput("req_ready", o_req_ready, reqOkPre);
        checkOutput("busy", o_busy, (cmdQ.size() != 0) || (outstanding != 0));
        checkOutput("rsp_valid", o_rsp_valid, rspQ.size() != 0);
        if (rspQ.size() != 0) checkOutput("rsp_data", o_rsp_data, rspQ[0]);
        checkOutput("ren", o_backend_controller_ren, !fullPre);
        checkOutput("overflow", o_overflow_err, ovfM);
        if (stallPrev) begin
            checkOutput("hold_valid", o_frontend_command_valid, 1'b1);
            checkOutput("hold_cmd", o_frontend_command, prevCmd);
            checkOutput("hold_wdata", o_frontend_write_data, prevWd);
        end

        issuable = (cmdQ.size() != 0) &&
                   (cmdQ[0][CMD_W-1] || (outstanding + rspQ.size() < RD_DEPTH));
        if (issuable && !o_frontend_command_valid) stallCnt++; else stallCnt = 0;
        if (stallCnt > 3) begin
            checkOutput("liveness", o_frontend_command_valid, 1'b1);
            stallCnt = 0;
        end

        if (o_frontend_command_valid && i_backend_controller_ready) begin
            if (cmdQ.size() == 0) begin
                checkOutput("spurious_issue", o_frontend_command_valid, 1'b0);
            end else begin
                checkOutput("cmd", o_frontend_command, cmdQ[0]);
                if (cmdQ[0][CMD_W-1]) begin
                    checkOutput("wdata", o_frontend_write_data, wdQ[0]);
                end else begin
                    checkOutput("read_credit", o_frontend_command_valid,
                                (outstanding + rspQ.size()) < RD_DEPTH);
                    outstanding++;
                end
                void'(cmdQ.pop_front());
                void'(wdQ.pop_front());
                acceptCount++;
            end
        end

        if (o_frontend_command_valid) validRun++; else validRun = 0;
        if (validRun > maxRun) maxRun = validRun;
        stallPrev = o_frontend_command_valid && !i_backend_controller_ready;
        prevCmd   = o_frontend_command;
        prevWd    = o_frontend_write_data;

        if (popPre) void'(rspQ.pop_front());
        if (i_backend_read_data_valid) begin
            if (outPre > 0) outstanding--;
            if (fullPre) ovfM = 1'b1;
            else rspQ.push_back(i_backend_read_data);
        end
        if (i_req_valid && reqOkPre) begin
            cmdQ.push_back({i_req_op, i_req_row, i_req_col});
            wdQ.push_back(i_req_wdata);
            pushed = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic op, input logic [ROW_W-1:0] row,
                                 input logic [COL_W-1:0] col, input logic [DATA_W-1:0] wd);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_row   = row;
        i_req_col   = col;
        i_req_wdata = wd;
        pushed      = 1'b0;
        while (!pushed && n < 40) begin
            stepCycle();
            n++;
        end
        i_req_valid = 1'b0;
        if (!pushed) checkOutput("push_timeout", o_req_ready, 1'b1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, o_frontend_command_valid, 1'b0);
        checkOutput({tag, "_busy"}, o_busy, 1'b0);
        checkOutput({tag, "_ovf"}, o_overflow_err, 1'b0);
        checkOutput({tag, "_req_ready"}, o_req_ready, 1'b1);
        checkOutput({tag, "_ren"}, o_backend_controller_ren, 1'b1);
        checkOutput({tag, "_rsp_valid"}, o_rsp_valid, 1'b0);
    endtask

    task automatic doReset();
        power_on_rst               = 1'b1;
        i_req_valid                = 1'b0;
        i_req_op                   = 1'b0;
        i_req_row                  = '0;
        i_req_col                  = '0;
        i_req_wdata                = '0;
        i_backend_controller_ready = 1'b0;
        i_backend_read_data_valid  = 1'b0;
        i_backend_read_data        = '0;
        i_rsp_ready                = 1'b0;
        repeat (2) @(negedge clk);
        cmdQ.delete();
        wdQ.delete();
        rspQ.delete();
        outstanding = 0;
        ovfM        = 1'b0;
        stallPrev   = 1'b0;
        stallCnt    = 0;
        validRun    = 0;
        maxRun      = 0;
        acceptCount = 0;
        checkResetOutputs("reset");
        power_on_rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        i_req_valid                = 1'b0;
        i_backend_controller_ready = 1'b1;
        i_rsp_ready                = 1'b1;
        while ((cmdQ.size() != 0 || outstanding != 0 || rspQ.size() != 0) && n < 300) begin
            i_backend_read_data_valid = (outstanding > 0) && ($urandom_range(0, 1) == 1);
            i_backend_read_data       = randData();
            stepCycle();
            n++;
        end
        i_backend_read_data_valid = 1'b0;
        checkOutput("drain_idle", o_busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);

        // Single write: two-cycle latency, payload held under backpressure, busy drops after accept.
        doReset();
        applyStimulus(1'b1, 16'h0012, 4'h3, {16{8'hA5}});
        checkOutput("t1_lat1", o_frontend_command_valid, 1'b0);
        stepCycle();
        checkOutput("t1_lat2", o_frontend_command_valid, 1'b1);
        checkOutput("t1_cmd", o_frontend_command, {1'b1, 16'h0012, 4'h3});
        checkOutput("t1_wdata", o_frontend_write_data, {16{8'hA5}});
        repeat (5) stepCycle();
        i_backend_controller_ready = 1'b1;
        stepCycle();
        i_backend_controller_ready = 1'b0;
        checkOutput("t1_busy", o_busy, 1'b0);
        checkOutput("t1_valid_after", o_frontend_command_valid, 1'b0);

        // Command FIFO fill: ready drops at eight, ninth held, one drain re-raises ready.
        doReset();
        for (int i = 0; i < CMD_DEPTH; i++) applyStimulus(1'b1, ROW_W'(i), COL_W'(i), randData());
        checkOutput("t2_full", o_req_ready, 1'b0);
        i_req_valid = 1'b1;
        i_req_op    = 1'b1;
        i_req_row   = 16'h0009;
        i_req_col   = 4'h9;
        i_req_wdata = randData();
        repeat (3) stepCycle();
        checkOutput("t2_held", o_req_ready, 1'b0);
        i_backend_controller_ready = 1'b1;
        stepCycle();
        i_backend_controller_ready = 1'b0;
        checkOutput("t2_reraise", o_req_ready, 1'b1);
        stepCycle();
        i_req_valid = 1'b0;
        checkOutput("t2_refull", o_req_ready, 1'b0);
        drain();

        // Credit limit: six reads, only four issue until a return frees a credit.
        doReset();
        i_backend_controller_ready = 1'b1;
        i_rsp_ready                = 1'b1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, ROW_W'(16'h100 + i), COL_W'(i), '0);
        repeat (10) stepCycle();
        checkOutput("t3_issued", 32'(acceptCount), 32'd4);
        checkOutput("t3_held", o_frontend_command_valid, 1'b0);
        i_backend_read_data_valid = 1'b1;
        i_backend_read_data       = randData();
        stepCycle();
        i_backend_read_data_valid = 1'b0;
        for (int n = 0; n < 10 && acceptCount < 5; n++) stepCycle();
        checkOutput("t3_resume", 32'(acceptCount), 32'd5);
        drain();

        // Return buffer full with host stalled, then an unsolicited beat overflows.
        doReset();
        i_backend_controller_ready = 1'b1;
        for (int i = 0; i < RD_DEPTH; i++) applyStimulus(1'b0, ROW_W'(i), 4'hF, '0);
        repeat (6) stepCycle();
        for (int i = 0; i < RD_DEPTH; i++) begin
            i_backend_read_data_valid = 1'b1;
            i_backend_read_data       = randData();
            stepCycle();
        end
        i_backend_read_data_valid = 1'b0;
        stepCycle();
        checkOutput("t4_ren", o_backend_controller_ren, 1'b0);
        checkOutput("t4_rsp_valid", o_rsp_valid, 1'b1);
        i_backend_read_data_valid = 1'b1;
        i_backend_read_data       = randData();
        stepCycle();
        i_backend_read_data_valid = 1'b0;
        checkOutput("t4_ovf", o_overflow_err, 1'b1);
        i_rsp_ready = 1'b1;
        repeat (6) stepCycle();
        checkOutput("t4_ovf_sticky", o_overflow_err, 1'b1);

        // Back-to-back write/read/write at column 15.
        doReset();
        i_backend_controller_ready = 1'b1;
        i_rsp_ready                = 1'b1;
        applyStimulus(1'b1, 16'h1234, 4'hF, randData());
        applyStimulus(1'b0, 16'h00FF, 4'hF, '0);
        applyStimulus(1'b1, 16'hFFFF, 4'hF, randData());
        repeat (4) stepCycle();
        checkOutput("t5_run", 32'(maxRun), 32'd3);
        i_backend_read_data_valid = 1'b1;
        i_backend_read_data       = randData();
        stepCycle();
        i_backend_read_data_valid = 1'b0;
        drain();

        // Reset with queued commands and outstanding reads.
        doReset();
        i_backend_controller_ready = 1'b1;
        applyStimulus(1'b0, 16'h0001, 4'h1, '0);
        applyStimulus(1'b0, 16'h0002, 4'h2, '0);
        repeat (4) stepCycle();
        i_backend_controller_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, ROW_W'(i), COL_W'(i), randData());
        stepCycle();
        power_on_rst = 1'b1;
        #1;
        checkResetOutputs("t6");
        doReset();
        repeat (4) stepCycle();

        // Random traffic.
        doReset();
        for (int c = 0; c < 1500; c++) begin
            i_req_valid                = ($urandom_range(0, 1) == 1);
            i_req_op                   = ($urandom_range(0, 1) == 1);
            i_req_row                  = ROW_W'($urandom());
            i_req_col                  = COL_W'($urandom());
            i_req_wdata                = randData();
            i_backend_controller_ready = ($urandom_range(0, 9) < 6);
            i_backend_read_data_valid  = (outstanding > 0) && ($urandom_range(0, 1) == 1);
            i_backend_read_data        = randData();
            i_rsp_ready                = ($urandom_range(0, 9) < 7);
            stepCycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
